// File: rtl/rmii_rx_deframer.sv
// RMII receive deframer: strips preamble/SFD, assembles LSB-first dibits into bytes, flags frame end.
// Optional CRC-32 FCS check is compiled in when RMII_RX_FCS_CHECK_EN is defined.
module rmii_rx_deframer #(
  parameter int MIN_BYTES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       crsdv,
  input  logic [1:0] rxd,
  output logic       axiov,
  output logic [7:0] axiod,
  output logic       frame_done,
  output logic       frame_err,
  output logic       fcs_ok
);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  localparam logic [31:0] MIN_LEN = MIN_BYTES;

  state_t      state;
  logic [1:0]  dibit_cnt;
  logic [7:0]  shreg;
  logic [10:0] byte_cnt;
  logic        armed;
  logic [7:0]  next_byte;
  logic        short_frame;
  logic        partial;
  logic        fcs_bad;
  logic        sfd_seen;
  logic        byte_done;
  logic        frame_end;

  assign next_byte   = {rxd, shreg[7:2]};
  assign short_frame = {21'd0, byte_cnt} < MIN_LEN;
  assign partial     = dibit_cnt != 2'd0;
  assign sfd_seen    = (state == PREAMBLE) && crsdv && (rxd == 2'b11);
  assign byte_done   = (state == DATA) && crsdv && (dibit_cnt == 2'd3);
  assign frame_end   = (state == DATA) && !crsdv;

`ifdef RMII_RX_FCS_CHECK_EN
  logic [31:0] crc;
  logic        crc_good;

  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Running the CRC over the FCS bytes too leaves a constant residue on a good frame.
  assign crc_good = crc == 32'hDEBB20E3;
  assign fcs_bad  = !crc_good;

  always_ff @(posedge clk) begin
    if (rst) begin
      crc    <= 32'hFFFFFFFF;
      fcs_ok <= 1'b0;
    end else begin
      fcs_ok <= 1'b0;
      if (sfd_seen)
        crc <= 32'hFFFFFFFF;
      else if (byte_done)
        crc <= crc_next(crc, next_byte);
      if (frame_end)
        fcs_ok <= crc_good && !partial;
    end
  end
`else
  assign fcs_bad = 1'b0;
  assign fcs_ok  = 1'b0;
`endif

  // armed blocks a frame already in flight when reset releases; it needs crsdv low once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      axiov      <= 1'b0;
      axiod      <= 8'd0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      dibit_cnt  <= 2'd0;
      shreg      <= 8'd0;
      byte_cnt   <= 11'd0;
      armed      <= 1'b0;
    end else begin
      axiov      <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (!crsdv)
        armed <= 1'b1;
      case (state)
        IDLE: begin
          if (armed && crsdv && rxd == 2'b01)
            state <= PREAMBLE;
        end
        PREAMBLE: begin
          if (!crsdv)
            state <= IDLE;
          else if (rxd == 2'b11) begin
            state     <= DATA;
            dibit_cnt <= 2'd0;
            shreg     <= 8'd0;
            byte_cnt  <= 11'd0;
          end else if (rxd != 2'b01)
            state <= DROP;
        end
        DATA: begin
          if (crsdv) begin
            shreg     <= next_byte;
            dibit_cnt <= dibit_cnt + 2'd1;
            if (dibit_cnt == 2'd3) begin
              axiov <= 1'b1;
              axiod <= next_byte;
              if (byte_cnt != 11'd2047)
                byte_cnt <= byte_cnt + 11'd1;
            end
          end else begin
            state      <= IDLE;
            frame_done <= 1'b1;
            frame_err  <= partial || short_frame || fcs_bad;
          end
        end
        DROP: begin
          if (!crsdv)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rmii_rx_deframer.sv
// Directed bench for rmii_rx_deframer; expectations adapt to RMII_RX_FCS_CHECK_EN.
module tb_rmii_rx_deframer;

  typedef logic [7:0] bq_t[$];

`ifdef RMII_RX_FCS_CHECK_EN
  localparam bit FCS_EN = 1'b1;
`else
  localparam bit FCS_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       crsdv = 1'b0;
  logic [1:0] rxd = 2'b00;
  logic       axiov;
  logic [7:0] axiod;
  logic       frame_done;
  logic       frame_err;
  logic       fcs_ok;

  int total = 0;
  int bad = 0;
  int stray = 0;
  logic [7:0] rx_q[$];
  logic [1:0] done_q[$];

  rmii_rx_deframer #(.MIN_BYTES(64)) dut (
    .clk(clk), .rst(rst), .crsdv(crsdv), .rxd(rxd),
    .axiov(axiov), .axiod(axiod), .frame_done(frame_done),
    .frame_err(frame_err), .fcs_ok(fcs_ok)
  );

  always #10 clk = ~clk;

  // Outputs are registered on posedge, so the falling edge sees them settled.
  always @(negedge clk) begin
    if (axiov === 1'b1) rx_q.push_back(axiod);
    if (frame_done === 1'b1) done_q.push_back({frame_err, fcs_ok});
    if (frame_done !== 1'b1 && (frame_err === 1'b1 || fcs_ok === 1'b1)) stray++;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic drive(input logic c, input logic [1:0] d);
    @(negedge clk);
    crsdv = c;
    rxd = d;
  endtask

  task automatic send_preamble();
    repeat (31) drive(1'b1, 2'b01);
    drive(1'b1, 2'b11);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 4; i++) drive(1'b1, b[2*i +: 2]);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 2'b00);
  endtask

  task automatic send_frame(input bq_t q, input int extra);
    send_preamble();
    foreach (q[i]) send_byte(q[i]);
    repeat (extra) drive(1'b1, 2'b10);
    drive(1'b0, 2'b00);
  endtask

  function automatic bq_t make_frame(input int n, input logic [7:0] first);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(first + 8'(i));
    return q;
  endfunction

  function automatic bq_t add_fcs(input bq_t q);
    logic [31:0] c;
    bq_t r;
    r = q;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      c = c ^ {24'd0, q[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) r.push_back(c[8*k +: 8]);
    return r;
  endfunction

  task automatic clear_mon();
    rx_q.delete();
    done_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({axiov, axiod, frame_done, frame_err, fcs_ok} !== 12'h000) begin
        bad++;
        $display("[TB] FAIL reset_outputs cycle %0d: got %h want 000", i,
                 {axiov, axiod, frame_done, frame_err, fcs_ok});
      end
      crsdv = 1'b1;
      rxd = 2'(i + 1);
    end
    // Release reset in the middle of something that looks like a frame.
    @(negedge clk);
    rst = 1'b0;
    crsdv = 1'b1;
    rxd = 2'b01;
    repeat (10) drive(1'b1, 2'b01);
    drive(1'b1, 2'b11);
    for (int i = 0; i < 6; i++) send_byte(8'h30 + 8'(i));
    idle(3);
    total++;
    if (rx_q.size() !== 0) begin
      bad++;
      $display("[TB] FAIL reset_release_bytes: got %0d want 0", rx_q.size());
    end
    total++;
    if (done_q.size() !== 0) begin
      bad++;
      $display("[TB] FAIL reset_release_done: got %0d want 0", done_q.size());
    end
    clear_mon();
  endtask

  task automatic test_reset_midframe();
    clear_mon();
    send_preamble();
    for (int i = 0; i < 5; i++) send_byte(8'h40 + 8'(i));
    @(negedge clk);
    rst = 1'b1;
    crsdv = 1'b1;
    rxd = 2'b10;
    drive(1'b1, 2'b10);
    @(negedge clk);
    rst = 1'b0;
    clear_mon();
    repeat (4) send_byte(8'h55);
    send_byte(8'hFF);
    for (int i = 0; i < 20; i++) send_byte(8'(i));
    idle(3);
    total++;
    if (rx_q.size() !== 0) begin
      bad++;
      $display("[TB] FAIL midreset_bytes: got %0d want 0", rx_q.size());
    end
    total++;
    if (done_q.size() !== 0) begin
      bad++;
      $display("[TB] FAIL midreset_done: got %0d want 0", done_q.size());
    end
  endtask

  task automatic test_valid_frame();
    bq_t q;
    logic [7:0] first;
    logic [1:0] d;
    int errs;
    clear_mon();
    q = add_fcs(make_frame(60, 8'h00));
    send_frame(q, 0);
    idle(3);
    total++;
    if (rx_q.size() !== 64) begin
      bad++;
      $display("[TB] FAIL valid_count: got %0d want 64", rx_q.size());
    end
    first = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
    total++;
    if (first !== 8'h00) begin
      bad++;
      $display("[TB] FAIL valid_first: got %h want 00", first);
    end
    errs = 0;
    for (int i = 0; i < rx_q.size() && i < 64; i++) if (rx_q[i] !== q[i]) errs++;
    total++;
    if (errs !== 0) begin
      bad++;
      $display("[TB] FAIL valid_payload: got %0d wrong bytes want 0", errs);
    end
    total++;
    if (done_q.size() !== 1) begin
      bad++;
      $display("[TB] FAIL valid_done: got %0d want 1", done_q.size());
    end
    d = (done_q.size() > 0) ? done_q[0] : 2'bxx;
    total++;
    if (d !== {1'b0, FCS_EN}) begin
      bad++;
      $display("[TB] FAIL valid_err_fcs: got %b want %b", d, {1'b0, FCS_EN});
    end
  endtask

  task automatic test_byte_order();
    logic [1:0] d;
    clear_mon();
    send_preamble();
    drive(1'b1, 2'b01);
    drive(1'b1, 2'b01);
    drive(1'b1, 2'b10);
    @(negedge clk);
    total++;
    if (axiov !== 1'b0) begin
      bad++;
      $display("[TB] FAIL order_early: got axiov=%b want 0", axiov);
    end
    crsdv = 1'b1;
    rxd = 2'b10;
    @(negedge clk);
    total++;
    if ({axiov, axiod} !== 9'h1A5) begin
      bad++;
      $display("[TB] FAIL order_byte: got %b/%h want 1/a5", axiov, axiod);
    end
    crsdv = 1'b0;
    rxd = 2'b00;
    @(negedge clk);
    total++;
    if ({axiov, axiod} !== 9'h0A5) begin
      bad++;
      $display("[TB] FAIL order_hold: got %b/%h want 0/a5", axiov, axiod);
    end
    idle(2);
    d = (done_q.size() == 1) ? done_q[0] : 2'bxx;
    total++;
    if (d !== 2'b10) begin
      bad++;
      $display("[TB] FAIL order_runt_flags: got %b want 10", d);
    end
  endtask

  task automatic test_partial();
    bq_t q;
    logic [1:0] d;
    q = add_fcs(make_frame(60, 8'h80));
    for (int extra = 2; extra <= 3; extra++) begin
      clear_mon();
      send_frame(q, extra);
      idle(3);
      total++;
      if (rx_q.size() !== 64) begin
        bad++;
        $display("[TB] FAIL partial%0d_count: got %0d want 64", extra, rx_q.size());
      end
      d = (done_q.size() == 1) ? done_q[0] : 2'bxx;
      total++;
      if (d !== 2'b10) begin
        bad++;
        $display("[TB] FAIL partial%0d_flags: got %b want 10", extra, d);
      end
    end
  endtask

  task automatic test_runt();
    bq_t q;
    logic [1:0] d;
    clear_mon();
    q = add_fcs(make_frame(6, 8'h20));
    send_frame(q, 0);
    idle(3);
    total++;
    if (rx_q.size() !== 10) begin
      bad++;
      $display("[TB] FAIL runt_count: got %0d want 10", rx_q.size());
    end
    d = (done_q.size() == 1) ? done_q[0] : 2'bxx;
    total++;
    if (d !== {1'b1, FCS_EN}) begin
      bad++;
      $display("[TB] FAIL runt_flags: got %b want %b", d, {1'b1, FCS_EN});
    end
  endtask

  task automatic test_bad_preamble();
    clear_mon();
    drive(1'b1, 2'b01);
    drive(1'b1, 2'b01);
    drive(1'b1, 2'b10);
    repeat (20) drive(1'b1, 2'b01);
    drive(1'b1, 2'b11);
    for (int i = 0; i < 8; i++) send_byte(8'h11 * 8'(i));
    idle(3);
    total++;
    if (rx_q.size() !== 0) begin
      bad++;
      $display("[TB] FAIL drop_bytes: got %0d want 0", rx_q.size());
    end
    total++;
    if (done_q.size() !== 0) begin
      bad++;
      $display("[TB] FAIL drop_done: got %0d want 0", done_q.size());
    end
  endtask

  task automatic test_back_to_back();
    bq_t q1;
    bq_t q2;
    logic [1:0] d0;
    logic [1:0] d1;
    clear_mon();
    q1 = add_fcs(make_frame(60, 8'h10));
    q1[5] = q1[5] ^ 8'h01;
    q2 = add_fcs(make_frame(60, 8'hC0));
    send_frame(q1, 0);
    send_frame(q2, 0);
    idle(3);
    total++;
    if (rx_q.size() !== 128) begin
      bad++;
      $display("[TB] FAIL b2b_count: got %0d want 128", rx_q.size());
    end
    total++;
    if (done_q.size() !== 2) begin
      bad++;
      $display("[TB] FAIL b2b_done: got %0d want 2", done_q.size());
    end
    d0 = (done_q.size() > 0) ? done_q[0] : 2'bxx;
    d1 = (done_q.size() > 1) ? done_q[1] : 2'bxx;
    total++;
    if (d0 !== {FCS_EN, 1'b0}) begin
      bad++;
      $display("[TB] FAIL b2b_corrupt_flags: got %b want %b", d0, {FCS_EN, 1'b0});
    end
    total++;
    if (d1 !== {1'b0, FCS_EN}) begin
      bad++;
      $display("[TB] FAIL b2b_good_flags: got %b want %b", d1, {1'b0, FCS_EN});
    end
  endtask

  initial begin
    test_reset();
    test_reset_midframe();
    test_valid_frame();
    test_byte_order();
    test_partial();
    test_runt();
    test_bad_preamble();
    test_back_to_back();
    total++;
    if (stray !== 0) begin
      bad++;
      $display("[TB] FAIL stray_flags: got %0d want 0", stray);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
